bus_txn_arbiter: RTL and testbench
==================================

BUS_TXN_ARBITER -- requirements
Module: bus_txn_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles a granted transaction may wait for m_ready before forced error; legal range 2..65535.
REQ-002 SHALL have parameter MAX_DBUS_STREAK, default 4: consecutive dbus grants allowed while ibus waits; legal range 1..15.
REQ-003 SHALL have one clock and an asynchronous, active-high reset (clk, rst).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 ibus_req in 1, ibus_addr in 32: instruction fetch request; always a read.
REQ-007 ibus_rdata out 32, ibus_ready out 1, ibus_error out 1: instruction response.
REQ-008 dbus_req in 1, dbus_we in 1, dbus_addr in 32, dbus_wdata in 32, dbus_wstrb in 4: data request.
REQ-009 dbus_rdata out 32, dbus_ready out 1, dbus_error out 1: data response.
REQ-010 m_req out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_wstrb out 4: single downstream request to the address decoder.
REQ-011 m_rdata in 32, m_ready in 1, m_error in 1: downstream response.
REQ-012 grant_owner out 2: 00 none, 01 ibus, 10 dbus, 11 timeout-error cycle.
REQ-013 timeout_pulse out 1: one-cycle strobe per forced timeout.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, TERR; a transaction, once granted, SHALL own the downstream port until completion (no mid-transaction switch).
REQ-015 IDLE: at clock edge, dbus_req and not starved -> GRANT_D; else ibus_req -> GRANT_I; else stay IDLE.
REQ-016 Starvation: dbus_streak (4-bit) SHALL increment on each IDLE->GRANT_D taken while ibus_req=1; clear on IDLE->GRANT_I or on any arbitration with ibus_req=0; when streak == MAX_DBUS_STREAK and ibus_req=1, ibus SHALL win.
REQ-017 Latency: request sampled at edge N -> m_req=1 from cycle N+1; no combinational req-to-m_req path.
REQ-018 GRANT_I: m_req=1, m_we=0, m_addr=ibus_addr, m_wdata=0, m_wstrb=4'hF; GRANT_D: m_* = dbus_* fields.
REQ-019 In GRANT_x, owner ready/error/rdata SHALL equal m_ready/m_error/m_rdata combinationally; non-owner outputs 0.
REQ-020 m_ready=1 in GRANT_x -> IDLE next edge; one idle bubble between transactions.
REQ-021 Masters SHALL hold req and fields stable until ready; req dropping in GRANT_x without m_ready -> IDLE next edge, no response, streak unchanged.
REQ-022 Watchdog: 16-bit wait counter clears on entering GRANT_x, increments each GRANT_x cycle with m_ready=0; when counter == TIMEOUT_CYCLES-1 and m_ready=0 -> TERR next edge.
REQ-023 m_ready arriving in the same cycle as the timeout threshold SHALL complete normally (ready wins).
REQ-024 TERR (one cycle): m_req=0; owner ready=1, error=1, rdata=0; timeout_pulse=1; grant_owner=11; then IDLE.
REQ-025 Late m_ready while IDLE or TERR SHALL be ignored.
REQ-026 All outputs not driven by an active state SHALL be 0.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, streak=0, wait counter=0, all outputs 0 (m_req=0, *_ready=0, *_error=0, grant_owner=00, timeout_pulse=0).
REQ-028 Reset mid-transaction SHALL abandon it with no response; first arbitration on first edge after rst deasserts.

Verification
REQ-029 Simultaneous ibus_req and dbus_req (dbus addr 0x100, we=1, wdata 0xDEADBEEF), m_ready after 2 cycles -> GRANT_D first, m_wdata=0xDEADBEEF, dbus_ready=1, ibus_ready=0; ibus granted after the bubble.
REQ-030 dbus_req held continuously with ibus_req=1, MAX_DBUS_STREAK=4 -> exactly 4 dbus grants then 1 ibus grant, repeating.
REQ-031 m_ready never asserted, TIMEOUT_CYCLES=8 -> m_req high exactly 8 cycles, then one cycle ibus_ready=1, ibus_error=1, rdata=0, timeout_pulse=1.
REQ-032 m_ready=1 at wait count 7 with TIMEOUT_CYCLES=8 -> normal completion, timeout_pulse stays 0.
REQ-033 rst asserted in GRANT_D mid-wait -> same-cycle m_req=0, dbus_ready=0, grant_owner=00; after release, pending ibus_req granted at first edge.
REQ-034 m_error=1 with m_ready=1 for ibus fetch to 0x20000000 -> ibus_error=1 that cycle, FSM to IDLE, timeout_pulse=0.

Source files
------------

// File: rtl/bus_txn_arbiter_if.sv
// Upstream ibus/dbus ports, the single downstream m_* port and arbiter status.
interface bus_txn_arbiter_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_ready;
    logic        ibus_error;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_rdata;
    logic        dbus_ready;
    logic        dbus_error;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_error;
    logic [1:0]  grant_owner;
    logic        timeout_pulse;

    modport slave (
        input  ibus_req, ibus_addr,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  m_rdata, m_ready, m_error,
        output ibus_rdata, ibus_ready, ibus_error,
        output dbus_rdata, dbus_ready, dbus_error,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        output grant_owner, timeout_pulse
    );

    modport master (
        output ibus_req, ibus_addr,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output m_rdata, m_ready, m_error,
        input  ibus_rdata, ibus_ready, ibus_error,
        input  dbus_rdata, dbus_ready, dbus_error,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  grant_owner, timeout_pulse
    );
endinterface

// File: rtl/bus_txn_arbiter.sv
// Two-master (ibus/dbus) arbiter onto one downstream port with
// dbus-priority, ibus anti-starvation and a per-transaction watchdog.
module bus_txn_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned MAX_DBUS_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    bus_txn_arbiter_if.slave b
);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DBUS_STREAK);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TERR} state_t;

    state_t      state_q;
    logic [3:0]  streak_q;
    logic [15:0] wait_q;
    logic        own_i_q;
    logic        m_req_q;
    logic        tpulse_q;
    logic [1:0]  owner_q;

    logic starved;
    logic cur_req;
    logic g_i;
    logic g_d;
    logic t_i;
    logic t_d;

    assign starved = b.ibus_req && (streak_q == STREAK_MAX);
    assign cur_req = (state_q == GRANT_I) ? b.ibus_req : b.dbus_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wait_q   <= '0;
            own_i_q  <= 1'b0;
            m_req_q  <= 1'b0;
            tpulse_q <= 1'b0;
            owner_q  <= 2'b00;
        end else begin
            tpulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wait_q <= '0;
                    if (b.dbus_req && !starved) begin
                        state_q  <= GRANT_D;
                        own_i_q  <= 1'b0;
                        m_req_q  <= 1'b1;
                        owner_q  <= 2'b10;
                        streak_q <= b.ibus_req ? streak_q + 4'd1 : 4'd0;
                    end else if (b.ibus_req) begin
                        state_q  <= GRANT_I;
                        own_i_q  <= 1'b1;
                        m_req_q  <= 1'b1;
                        owner_q  <= 2'b01;
                        streak_q <= '0;
                    end else begin
                        streak_q <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // ready wins over the watchdog threshold
                    if (b.m_ready || !cur_req) begin
                        state_q <= IDLE;
                        m_req_q <= 1'b0;
                        owner_q <= 2'b00;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q  <= TERR;
                        m_req_q  <= 1'b0;
                        owner_q  <= 2'b11;
                        tpulse_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                TERR: begin
                    state_q <= IDLE;
                    owner_q <= 2'b00;
                end
            endcase
        end
    end

    assign g_i = (state_q == GRANT_I);
    assign g_d = (state_q == GRANT_D);
    assign t_i = (state_q == TERR) && own_i_q;
    assign t_d = (state_q == TERR) && !own_i_q;

    assign b.m_req   = m_req_q;
    assign b.m_we    = g_d & b.dbus_we;
    assign b.m_addr  = g_i ? b.ibus_addr : (g_d ? b.dbus_addr : 32'd0);
    assign b.m_wdata = g_d ? b.dbus_wdata : 32'd0;
    assign b.m_wstrb = g_i ? 4'hF : (g_d ? b.dbus_wstrb : 4'h0);

    assign b.ibus_rdata = g_i ? b.m_rdata : 32'd0;
    assign b.ibus_ready = (g_i & b.m_ready) | t_i;
    assign b.ibus_error = (g_i & b.m_error) | t_i;
    assign b.dbus_rdata = g_d ? b.m_rdata : 32'd0;
    assign b.dbus_ready = (g_d & b.m_ready) | t_d;
    assign b.dbus_error = (g_d & b.m_error) | t_d;

    assign b.grant_owner   = owner_q;
    assign b.timeout_pulse = tpulse_q;
endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Scoreboard bench for bus_txn_arbiter: expected responses are queued at
// request time and popped when the DUT answers.
module tb_bus_txn_arbiter;
    localparam int TO   = 8;
    localparam int MAXS = 4;

    typedef struct packed {
        logic        ir;
        logic        dr;
        logic [31:0] rdata;
        logic        err;
        logic        tp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    bus_txn_arbiter_if bif();

    bus_txn_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .MAX_DBUS_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .b  (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t obs();
        exp_t o;
        o.ir    = bif.ibus_ready;
        o.dr    = bif.dbus_ready;
        o.rdata = bif.ibus_ready ? bif.ibus_rdata : bif.dbus_rdata;
        o.err   = bif.ibus_ready ? bif.ibus_error : bif.dbus_error;
        o.tp    = bif.timeout_pulse;
        return o;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '1;
        if (sbq.size() > 0) e = sbq.pop_front();
        return e;
    endfunction

    function automatic exp_t mk(bit i, logic [31:0] d, bit er, bit tp);
        exp_t e;
        e.ir = i;
        e.dr = !i;
        e.rdata = d;
        e.err = er;
        e.tp = tp;
        return e;
    endfunction

    task automatic test_reset();
        logic [7:0] o;
        bif.m_ready = 1'b1;
        bif.m_error = 1'b1;
        bif.dbus_req = 1'b1;
        repeat (2) tick();
        o = {bif.m_req, bif.ibus_ready, bif.ibus_error, bif.dbus_ready,
             bif.dbus_error, bif.timeout_pulse, bif.grant_owner};
        n_cmp++;
        if (o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 00", o);
        end
        bif.m_ready = 1'b0;
        bif.m_error = 1'b0;
        bif.dbus_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        exp_t o;
        tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h0000_1000;
        bif.dbus_req = 1'b1;
        bif.dbus_we = 1'b1;
        bif.dbus_addr = 32'h0000_0100;
        bif.dbus_wdata = 32'hDEAD_BEEF;
        bif.dbus_wstrb = 4'hF;
        bif.m_rdata = 32'h0;
        sbq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0));
        tick();
        n_cmp++;
        if ({bif.m_req, bif.grant_owner, bif.m_we} !== 4'b1101) begin
            n_err++;
            $display("FAIL sim_grant_d: got %b want 1101",
                     {bif.m_req, bif.grant_owner, bif.m_we});
        end
        n_cmp++;
        if ({bif.m_addr, bif.m_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL sim_fields: got %h/%h want 100/deadbeef",
                     bif.m_addr, bif.m_wdata);
        end
        tick();
        bif.m_ready = 1'b1;
        #1;
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL sim_dresp: got %h want %h", o, e);
        end
        tick();
        bif.m_ready = 1'b0;
        bif.dbus_req = 1'b0;
        bif.dbus_we = 1'b0;
        #1;
        n_cmp++;
        if ({bif.m_req, bif.grant_owner} !== 3'b000) begin
            n_err++;
            $display("FAIL sim_bubble: got %b want 000",
                     {bif.m_req, bif.grant_owner});
        end
        tick();
        n_cmp++;
        if ({bif.grant_owner, bif.m_we, bif.m_wstrb, bif.m_addr, bif.m_wdata}
            !== {2'b01, 1'b0, 4'hF, 32'h1000, 32'h0}) begin
            n_err++;
            $display("FAIL sim_grant_i: got %b %b %h %h %h want 01 0 f 1000 0",
                     bif.grant_owner, bif.m_we, bif.m_wstrb, bif.m_addr,
                     bif.m_wdata);
        end
        sbq.push_back(mk(1'b1, 32'h13, 1'b0, 1'b0));
        bif.m_ready = 1'b1;
        bif.m_rdata = 32'h13;
        #1;
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL sim_iresp: got %h want %h", o, e);
        end
        tick();
        bif.ibus_req = 1'b0;
        bif.m_ready = 1'b0;
    endtask

    task automatic test_streak();
        int ms;
        logic [1:0] want;
        exp_t e;
        exp_t o;
        ms = 0;
        tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h0000_3000;
        bif.dbus_req = 1'b1;
        bif.dbus_we = 1'b0;
        bif.dbus_addr = 32'h0000_0200;
        for (int k = 0; k < 10; k++) begin
            if (ms == MAXS) begin
                want = 2'b01;
                ms = 0;
            end else begin
                want = 2'b10;
                ms++;
            end
            sbq.push_back(mk(want == 2'b01, 32'(k + 100), 1'b0, 1'b0));
            tick();
            n_cmp++;
            if (bif.grant_owner !== want) begin
                n_err++;
                $display("FAIL streak_owner_%0d: got %b want %b",
                         k, bif.grant_owner, want);
            end
            bif.m_ready = 1'b1;
            bif.m_rdata = 32'(k + 100);
            #1;
            e = pop_exp();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL streak_resp_%0d: got %h want %h", k, o, e);
            end
            tick();
            bif.m_ready = 1'b0;
        end
        bif.ibus_req = 1'b0;
        bif.dbus_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        exp_t e;
        exp_t o;
        tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h0000_2000;
        bif.m_rdata = 32'hAAAA_5555;
        bif.m_ready = 1'b0;
        sbq.push_back(mk(1'b1, 32'h0, 1'b1, 1'b1));
        n = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!bif.m_req) break;
            n++;
        end
        n_cmp++;
        if (n !== TO) begin
            n_err++;
            $display("FAIL to_mreq_cycles: got %0d want %0d", n, TO);
        end
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL to_resp: got %h want %h", o, e);
        end
        n_cmp++;
        if (bif.grant_owner !== 2'b11) begin
            n_err++;
            $display("FAIL to_owner: got %b want 11", bif.grant_owner);
        end
        bif.ibus_req = 1'b0;
        bif.m_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bif.ibus_ready, bif.m_req, bif.timeout_pulse, bif.grant_owner}
            !== 5'b0) begin
            n_err++;
            $display("FAIL to_late_ready: got %b want 00000",
                     {bif.ibus_ready, bif.m_req, bif.timeout_pulse,
                      bif.grant_owner});
        end
        bif.m_ready = 1'b0;
    endtask

    task automatic test_ready_at_limit();
        exp_t e;
        exp_t o;
        tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h0000_2004;
        sbq.push_back(mk(1'b1, 32'h77, 1'b0, 1'b0));
        repeat (TO) tick();
        n_cmp++;
        if (bif.m_req !== 1'b1) begin
            n_err++;
            $display("FAIL lim_mreq: got %b want 1", bif.m_req);
        end
        bif.m_ready = 1'b1;
        bif.m_rdata = 32'h77;
        #1;
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL lim_resp: got %h want %h", o, e);
        end
        tick();
        bif.ibus_req = 1'b0;
        bif.m_ready = 1'b0;
        n_cmp++;
        if ({bif.timeout_pulse, bif.grant_owner, bif.m_req} !== 4'b0) begin
            n_err++;
            $display("FAIL lim_after: got %b want 0000",
                     {bif.timeout_pulse, bif.grant_owner, bif.m_req});
        end
    endtask

    task automatic test_error();
        exp_t e;
        exp_t o;
        tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h2000_0000;
        sbq.push_back(mk(1'b1, 32'h55, 1'b1, 1'b0));
        tick();
        n_cmp++;
        if (bif.m_addr !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL err_addr: got %h want 20000000", bif.m_addr);
        end
        bif.m_ready = 1'b1;
        bif.m_error = 1'b1;
        bif.m_rdata = 32'h55;
        #1;
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL err_resp: got %h want %h", o, e);
        end
        tick();
        bif.ibus_req = 1'b0;
        bif.m_ready = 1'b0;
        bif.m_error = 1'b0;
        n_cmp++;
        if ({bif.grant_owner, bif.m_req, bif.timeout_pulse} !== 4'b0) begin
            n_err++;
            $display("FAIL err_idle: got %b want 0000",
                     {bif.grant_owner, bif.m_req, bif.timeout_pulse});
        end
    endtask

    task automatic test_req_drop();
        tick();
        bif.dbus_req = 1'b1;
        bif.dbus_we = 1'b1;
        tick();
        bif.dbus_req = 1'b0;
        tick();
        n_cmp++;
        if ({bif.m_req, bif.grant_owner, bif.dbus_ready} !== 4'b0) begin
            n_err++;
            $display("FAIL drop_idle: got %b want 0000",
                     {bif.m_req, bif.grant_owner, bif.dbus_ready});
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t o;
        tick();
        bif.dbus_req = 1'b1;
        bif.dbus_we = 1'b1;
        bif.dbus_addr = 32'h0000_0300;
        bif.dbus_wdata = 32'h1;
        repeat (3) tick();
        bif.ibus_req = 1'b1;
        bif.ibus_addr = 32'h0000_4000;
        rst = 1'b1;
        bif.m_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bif.m_req, bif.dbus_ready, bif.grant_owner} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid: got %b want 0000",
                     {bif.m_req, bif.dbus_ready, bif.grant_owner});
        end
        bif.dbus_req = 1'b0;
        bif.dbus_we = 1'b0;
        bif.m_ready = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bif.grant_owner, bif.m_req} !== 3'b011) begin
            n_err++;
            $display("FAIL rst_first_grant: got %b want 011",
                     {bif.grant_owner, bif.m_req});
        end
        sbq.push_back(mk(1'b1, 32'h99, 1'b0, 1'b0));
        bif.m_ready = 1'b1;
        bif.m_rdata = 32'h99;
        #1;
        e = pop_exp();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL rst_iresp: got %h want %h", o, e);
        end
        tick();
        bif.ibus_req = 1'b0;
        bif.m_ready = 1'b0;
    endtask

    initial begin
        bif.ibus_req = 1'b0;
        bif.ibus_addr = '0;
        bif.dbus_req = 1'b0;
        bif.dbus_we = 1'b0;
        bif.dbus_addr = '0;
        bif.dbus_wdata = '0;
        bif.dbus_wstrb = '0;
        bif.m_rdata = '0;
        bif.m_ready = 1'b0;
        bif.m_error = 1'b0;
        test_reset();
        test_simultaneous();
        test_streak();
        test_timeout();
        test_ready_at_limit();
        test_error();
        test_req_drop();
        test_reset_mid();
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got expired want done");
        $fatal(1, "time limit");
    end
endmodule
